s2p_usb_rx: RTL and testbench
=============================

Name: s2p_usb_rx

Overview:
- Parametrised serial-to-parallel receiver for the USB host/slave datapath. It is the next generation of the plain S2P shifter.
- Takes one line bit per clock and optionally NRZI-decodes it. It optionally removes USB bit-stuffing, detects stuff violations, and assembles DATA_WIDTH-bit words in LSB- or MSB-first order.
- Completed words are handed to the packet layer over a done/outReady handshake, with overrun detection.

Parameters:
- DATA_WIDTH, 16, output word width (>=2)
- LSB_FIRST, 1, 1 = first received bit lands in dataOut[0]; 0 = first bit lands in dataOut[DATA_WIDTH-1]
- NRZI_EN, 1, 1 = NRZI-decode dataSIN; 0 = dataSIN is the data bit
- STUFF_EN, 1, 1 = bit-unstuffing and stuff-error checking active
- STUFF_LEN, 6, number of consecutive decoded 1s after which a stuffed 0 is expected

Ports:
- clk1x  in  1  bit clock, one line bit per rising edge
- reset  in  1  synchronous, active-low reset
- receiveFlag  in  1  level; high = receive window open, dataSIN valid every cycle
- dataSIN  in  1  serial line input
- outReady  in  1  consumer accepts dataOut at any edge where done=1
- dataOut  out  DATA_WIDTH  last completed word
- done  out  1  word valid, held until accepted
- busy  out  1  state==RECV
- stuffErr  out  1  sticky stuff violation flag
- overrun  out  1  sticky, word lost because the previous one was not accepted

Behaviour:
- Reset (reset=0 at an edge):
  - dataOut=0, done=0, busy=0, stuffErr=0, overrun=0.
  - Internal state: state=IDLE, shift register=0, bitCnt=0, onesCnt=0, prevLevel=1.
- States are IDLE, RECV and ERR.
- IDLE:
  - With receiveFlag=1, go to RECV and clear stuffErr, overrun, bitCnt, onesCnt; set prevLevel=1.
  - dataSIN in that same cycle is processed as bit 0 with prevLevel=1.
- RECV, every edge with receiveFlag=1:
  - NRZI_EN=1: decoded bit = (dataSIN==prevLevel); prevLevel<=dataSIN. NRZI_EN=0: decoded bit = dataSIN.
  - STUFF_EN=1 and onesCnt==STUFF_LEN:
    - Decoded 0 is a stuffed bit: drop it (not shifted, bitCnt unchanged) and set onesCnt<=0.
    - Decoded 1 is a violation: stuffErr<=1, state<=ERR, partial word discarded.
  - Otherwise the bit is accepted:
    - Shift: LSB_FIRST=1: sh<={bit, sh[W-1:1]}; else sh<={sh[W-2:0], bit}.
    - onesCnt<=bit ? onesCnt+1 : 0.
  - Accepted bit with bitCnt==DATA_WIDTH-1 completes a word:
    - dataOut<=assembled word including this bit; done<=1; bitCnt<=0.
    - onesCnt continues across the word boundary, because stuffing is frame-continuous.
  - Latency: done is high in the cycle after the edge sampling the word's last bit.
- RECV with receiveFlag=0: state<=IDLE; partial word, bitCnt and onesCnt are discarded. A pending done/dataOut is untouched.
- ERR:
  - No bits are processed and done is never set.
  - Leave to IDLE when receiveFlag=0. stuffErr remains set until the next IDLE->RECV transition.
- Handshake:
  - An edge with done=1 and outReady=1 clears done.
  - If a word completes on the same edge, done stays 1, dataOut takes the new word, and there is no overrun.
  - Word completes while done=1 and outReady=0: overrun<=1, dataOut overwritten with the new word (newest wins), done stays 1.
- outReady while done=0 is ignored.
- A reset low mid-word or mid-handshake takes priority over all other events. The reset-value rules apply at that edge.

Test Plan:
- Plain LSB-first word. Config: DATA_WIDTH=16, NRZI_EN=0, STUFF_EN=0, LSB_FIRST=1. Stimulus: receiveFlag=1, 0xA5C3 sent LSB first over 16 cycles, outReady=0. Response: dataOut=0xA5C3, done=1 the cycle after bit 15, busy=1 throughout.
- MSB-first order. Config as above but LSB_FIRST=0, same bit sequence. Response: dataOut=0xC3A5. Then pulse outReady=1 for one edge: done=0.
- NRZI decode. Config: DATA_WIDTH=8, NRZI_EN=1, STUFF_EN=0.
  - dataSIN held 1 for 8 cycles after start: dataOut=0xFF.
  - Next 8 bits toggling 0,1,0,1,...: dataOut=0x00 with overrun=1 (outReady kept 0).
- Unstuffing. Config: DATA_WIDTH=8, NRZI_EN=0, STUFF_EN=1. Stimulus: 1,1,1,1,1,1,0,1,1. Response: stuffed 0 dropped; dataOut=0xFF; done rises after the 9th cycle; stuffErr=0.
- Stuff violation. Same config. Stimulus: seven 1s. Response:
  - stuffErr=1 and busy=0 the cycle after the 7th bit; done stays 0.
  - Drop receiveFlag for 1 cycle, then raise it: stuffErr=0, busy=1.
- Mid-frame abort and reset:
  - Drop receiveFlag after 5 bits, then send a fresh 8-bit word 0x3C: dataOut=0x3C, so no stale bits.
  - Separately, assert reset=0 for one edge with done=1, overrun=1: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/s2p_usb_rx.sv
// USB receive-side serial-to-parallel converter: optional NRZI decode and
// bit-unstuffing, word assembly in either bit order, done/outReady handoff.
module s2p_usb_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int LSB_FIRST  = 1,
  parameter int NRZI_EN    = 1,
  parameter int STUFF_EN   = 1,
  parameter int STUFF_LEN  = 6
) (
  input  logic                  clk1x,
  input  logic                  reset,
  input  logic                  receiveFlag,
  input  logic                  dataSIN,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  done,
  output logic                  busy,
  output logic                  stuffErr,
  output logic                  overrun
);

  localparam int CNT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);

  typedef enum logic [1:0] {IDLE, RECV, ERR} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [ONES_W-1:0]     ones_cnt_q, ones_cnt_d;
  logic                  prev_level_q, prev_level_d;
  logic                  done_q, done_d;
  logic                  stuff_err_q, stuff_err_d;
  logic                  overrun_q, overrun_d;

  logic                  run;
  logic                  dec_bit;
  logic                  prev_eff;
  logic [CNT_W-1:0]      bit_cnt_eff;
  logic [ONES_W-1:0]     ones_eff;
  logic [DATA_WIDTH-1:0] shift_next;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    prev_level_d = prev_level_q;
    done_d       = done_q;
    stuff_err_d  = stuff_err_q;
    overrun_d    = overrun_q;
    run          = 1'b0;
    prev_eff     = prev_level_q;
    bit_cnt_eff  = bit_cnt_q;
    ones_eff     = ones_cnt_q;
    dec_bit      = 1'b0;
    shift_next   = shift_q;

    if (done_q && outReady) begin
      done_d = 1'b0;
    end

    // The opening edge of a frame is also its first data bit, so the
    // counters and NRZI reference are substituted with their fresh values.
    case (state_q)
      IDLE: begin
        if (receiveFlag) begin
          state_d     = RECV;
          stuff_err_d = 1'b0;
          overrun_d   = 1'b0;
          run         = 1'b1;
          prev_eff    = 1'b1;
          bit_cnt_eff = '0;
          ones_eff    = '0;
        end
      end
      RECV: begin
        if (receiveFlag) begin
          run = 1'b1;
        end else begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          ones_cnt_d = '0;
        end
      end
      ERR: begin
        if (!receiveFlag) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (run) begin
      dec_bit      = (NRZI_EN != 0) ? (dataSIN == prev_eff) : dataSIN;
      prev_level_d = (NRZI_EN != 0) ? dataSIN : prev_eff;
      bit_cnt_d    = bit_cnt_eff;
      ones_cnt_d   = ones_eff;
      shift_next   = (LSB_FIRST != 0) ? {dec_bit, shift_q[DATA_WIDTH-1:1]}
                                      : {shift_q[DATA_WIDTH-2:0], dec_bit};

      if ((STUFF_EN != 0) && (ones_eff == STUFF_MAX)) begin
        ones_cnt_d = '0;
        if (dec_bit) begin
          stuff_err_d = 1'b1;
          state_d     = ERR;
          bit_cnt_d   = '0;
        end
      end else begin
        shift_d = shift_next;
        if (!dec_bit) begin
          ones_cnt_d = '0;
        end else if (ones_eff != STUFF_MAX) begin
          ones_cnt_d = ones_eff + 1'b1;
        end
        if (bit_cnt_eff == LAST_BIT) begin
          data_out_d = shift_next;
          done_d     = 1'b1;
          bit_cnt_d  = '0;
          if (done_q && !outReady) begin
            overrun_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_eff + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk1x) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      data_out_q   <= '0;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      prev_level_q <= 1'b1;
      done_q       <= 1'b0;
      stuff_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      prev_level_q <= prev_level_d;
      done_q       <= done_d;
      stuff_err_q  <= stuff_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dataOut  = data_out_q;
  assign done     = done_q;
  assign busy     = (state_q == RECV);
  assign stuffErr = stuff_err_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_s2p_usb_rx.sv
// Directed bench for s2p_usb_rx: four differently configured instances,
// expected words queued as they are sent and checked when done is due.
module tb_s2p_usb_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rf;
  logic [3:0]  ordy;
  logic        sin;
  logic [15:0] dout_a, dout_b;
  logic [7:0]  dout_c, dout_d;
  logic [3:0]  done, busy, serr, ovr;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          inst;
    logic [15:0] word;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // a: plain LSB-first, b: plain MSB-first, c: NRZI only, d: unstuffing only
  s2p_usb_rx #(.DATA_WIDTH(16), .LSB_FIRST(1), .NRZI_EN(0), .STUFF_EN(0), .STUFF_LEN(6)) u_a (
    .clk1x(clk), .reset(rst_n), .receiveFlag(rf[0]), .dataSIN(sin), .outReady(ordy[0]),
    .dataOut(dout_a), .done(done[0]), .busy(busy[0]), .stuffErr(serr[0]), .overrun(ovr[0]));
  s2p_usb_rx #(.DATA_WIDTH(16), .LSB_FIRST(0), .NRZI_EN(0), .STUFF_EN(0), .STUFF_LEN(6)) u_b (
    .clk1x(clk), .reset(rst_n), .receiveFlag(rf[1]), .dataSIN(sin), .outReady(ordy[1]),
    .dataOut(dout_b), .done(done[1]), .busy(busy[1]), .stuffErr(serr[1]), .overrun(ovr[1]));
  s2p_usb_rx #(.DATA_WIDTH(8), .LSB_FIRST(1), .NRZI_EN(1), .STUFF_EN(0), .STUFF_LEN(6)) u_c (
    .clk1x(clk), .reset(rst_n), .receiveFlag(rf[2]), .dataSIN(sin), .outReady(ordy[2]),
    .dataOut(dout_c), .done(done[2]), .busy(busy[2]), .stuffErr(serr[2]), .overrun(ovr[2]));
  s2p_usb_rx #(.DATA_WIDTH(8), .LSB_FIRST(1), .NRZI_EN(0), .STUFF_EN(1), .STUFF_LEN(6)) u_d (
    .clk1x(clk), .reset(rst_n), .receiveFlag(rf[3]), .dataSIN(sin), .outReady(ordy[3]),
    .dataOut(dout_d), .done(done[3]), .busy(busy[3]), .stuffErr(serr[3]), .overrun(ovr[3]));

  function automatic logic [15:0] dout_of(input int i);
    case (i)
      0:       return dout_a;
      1:       return dout_b;
      2:       return {8'h00, dout_c};
      default: return {8'h00, dout_d};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // One bit per call: inputs change on the falling edge, DUT samples on the
  // next rising edge, and the call returns on the following falling edge.
  task automatic bit_cycle(input int inst, input logic b);
    rf[inst] = 1'b1;
    sin      = b;
    @(negedge clk);
  endtask

  task automatic idle_cycle(input int inst);
    rf[inst] = 1'b0;
    sin      = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bits(input int inst, input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) bit_cycle(inst, w[i]);
  endtask

  task automatic push_word(input int inst, input logic [15:0] w);
    exp_t e;
    e.inst = inst;
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic check_word(input int inst, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s scoreboard empty observed=%0h expected=queued word", tag, dout_of(inst));
      return;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, {15'd0, done[e.inst]}, 16'd1);
    chk({tag, "_data"}, dout_of(e.inst), e.word);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_dout"}, dout_of(i), 16'h0000);
      chk({tag, "_flags"}, {12'd0, done[i], busy[i], serr[i], ovr[i]}, 16'h0000);
    end
  endtask

  initial begin
    logic [15:0] pat;
    rst_n = 1'b0;
    rf    = 4'b0000;
    ordy  = 4'b0000;
    sin   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Plain LSB-first word, then a word completing on the accepting edge
    send_bits(0, 16'hA5C3, 15);
    chk("a_busy_mid", {15'd0, busy[0]}, 16'd1);
    chk("a_done_early", {15'd0, done[0]}, 16'd0);
    push_word(0, 16'hA5C3);
    bit_cycle(0, 1'b1);
    check_word(0, "a_word");
    chk("a_busy_end", {15'd0, busy[0]}, 16'd1);
    idle_cycle(0);
    chk("a_idle_busy", {15'd0, busy[0]}, 16'd0);
    chk("a_done_held", {15'd0, done[0]}, 16'd1);
    send_bits(0, 16'h1234, 15);
    ordy[0] = 1'b1;
    push_word(0, 16'h1234);
    bit_cycle(0, 1'b0);
    ordy[0] = 1'b0;
    check_word(0, "a_ack_same_edge");
    chk("a_no_overrun", {15'd0, ovr[0]}, 16'd0);
    idle_cycle(0);

    // MSB-first order and single-edge acknowledge
    push_word(1, 16'hC3A5);
    send_bits(1, 16'hA5C3, 16);
    check_word(1, "b_word");
    ordy[1] = 1'b1;
    idle_cycle(1);
    ordy[1] = 1'b0;
    chk("b_acked", {15'd0, done[1]}, 16'd0);
    @(negedge clk);
    chk("b_stays_clear", {15'd0, done[1]}, 16'd0);

    // NRZI: steady line decodes to ones, toggling line to zeros with overrun
    push_word(2, 16'h00FF);
    send_bits(2, 16'hFFFF, 8);
    check_word(2, "c_ones");
    chk("c_no_ovr", {15'd0, ovr[2]}, 16'd0);
    push_word(2, 16'h0000);
    send_bits(2, 16'hAAAA, 8);
    check_word(2, "c_zeros");
    chk("c_overrun", {15'd0, ovr[2]}, 16'd1);
    idle_cycle(2);

    // Unstuffing: six ones, stuffed zero, two ones
    pat = 16'h01BF;
    send_bits(3, pat, 8);
    chk("d_stuff_not_counted", {15'd0, done[3]}, 16'd0);
    push_word(3, 16'h00FF);
    bit_cycle(3, pat[8]);
    check_word(3, "d_unstuff");
    chk("d_no_err", {15'd0, serr[3]}, 16'd0);
    ordy[3] = 1'b1;
    idle_cycle(3);
    ordy[3] = 1'b0;

    // Stuff violation: seven ones
    send_bits(3, 16'h007F, 7);
    chk("d_viol_err", {15'd0, serr[3]}, 16'd1);
    chk("d_viol_busy", {15'd0, busy[3]}, 16'd0);
    chk("d_viol_done", {15'd0, done[3]}, 16'd0);
    bit_cycle(3, 1'b1);
    chk("d_err_hold", {14'd0, busy[3], serr[3]}, 16'd1);
    idle_cycle(3);
    chk("d_err_sticky", {14'd0, busy[3], serr[3]}, 16'd1);
    bit_cycle(3, 1'b0);
    chk("d_restart", {14'd0, busy[3], serr[3]}, 16'd2);

    // Abort after five bits, then a fresh word must carry no stale bits
    send_bits(3, 16'h000D, 4);
    idle_cycle(3);
    push_word(3, 16'h003C);
    send_bits(3, 16'h003C, 8);
    check_word(3, "d_after_abort");
    push_word(3, 16'h005A);
    send_bits(3, 16'h005A, 8);
    check_word(3, "d_newest_wins");
    chk("d_overrun", {15'd0, ovr[3]}, 16'd1);

    // Reset during a pending handshake with receive window open
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rf    = 4'b0000;
    check_reset_state("mid_reset");

    if (sb.size() != 0) begin
      total++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
